shift_cmd_sequencer: RTL and testbench

SHIFT_CMD_SEQUENCER -- requirements
Module: shift_cmd_sequencer

---
 rtl/shift_cmd_sequencer_pkg.sv | 32 +++
 rtl/shift_cmd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_shift_cmd_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// shift_cmd_sequencer_pkg
//
// Shared definitions for the shift command sequencer and for anything that
// sits beside it at the parent level (the universal shift register it drives).
//
//   SEL_*     : select encodings understood by the universal shift register
//   DIR_*     : command shift direction encodings
//   state_t   : sequencer FSM states
// ---------------------------------------------------------------------------
package shift_cmd_sequencer_pkg;

    // Universal shift register operation select
    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_SHR  = 2'd1;
    localparam logic [1:0] SEL_SHL  = 2'd2;
    localparam logic [1:0] SEL_LOAD = 2'd3;

    // Command shift direction
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage : shift_cmd_sequencer_pkg

// File: rtl/shift_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// shift_cmd_sequencer
//
// Turns one "load then shift N times" command into the cycle-by-cycle select
// and serial-input pattern for an external universal shift register, then
// returns the final parallel value and the bits that fell out of the register.
//
// Parameters
//   WIDTH        : register width
//   CW           : width of the shift count, clog2(WIDTH+1)
//
// Ports
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_data              : parallel value loaded first
//   cmd_dir               : 0 = shift right, 1 = shift left
//   cmd_count             : number of shifts after the load (clamped to WIDTH)
//   cmd_fill              : serial fill bits, bit i enters on shift i
//   select, p_din,
//   s_left_din,
//   s_right_din           : drive the universal shift register
//   p_dout, s_left_dout,
//   s_right_dout          : observed from the universal shift register
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data              : register contents after the last operation
//   rsp_bits              : exit bit of shift i in bit i, unused bits zero
// ---------------------------------------------------------------------------
module shift_cmd_sequencer
    import shift_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CW-1:0]    cmd_count,
    input  logic [WIDTH-1:0] cmd_fill,

    output logic [1:0]       select,
    output logic [WIDTH-1:0] p_din,
    output logic             s_left_din,
    output logic             s_right_din,
    input  logic [WIDTH-1:0] p_dout,
    input  logic             s_left_dout,
    input  logic             s_right_dout,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_bits
);

    state_t state;
    state_t next_state;

    // Command registered at acceptance
    logic [WIDTH-1:0] data_r;
    logic             dir_r;
    logic [WIDTH-1:0] fill_r;

    // Remaining shifts, plus a one-hot marker of the current shift index
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] bit_mask;

    logic [CW-1:0]    count_clamped;
    logic             exit_bit;

    // Shift counts beyond the register width would only push out fill bits
    // that were never loaded, so they saturate at WIDTH.
    assign count_clamped = (cmd_count > CW'(WIDTH)) ? CW'(WIDTH) : cmd_count;

    // A right shift pushes the bit out through s_left_dout, a left shift
    // through s_right_dout.
    assign exit_bit = (dir_r == DIR_LEFT) ? s_right_dout : s_left_dout;

    // Gating with rst keeps cmd_ready low for the whole reset pulse even
    // though the state register already sits in IDLE.
    assign cmd_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and Moore output decode. Outputs depend only on the state
    // and registered command fields, never on cmd_* or rsp_ready directly.
    always_comb begin
        next_state  = state;
        select      = SEL_HOLD;
        p_din       = '0;
        s_left_din  = 1'b0;
        s_right_din = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    next_state = LOAD;
                end
            end

            LOAD: begin
                select = SEL_LOAD;
                p_din  = data_r;
                if (count_r == '0) begin
                    next_state = CAPTURE;
                end else begin
                    next_state = SHIFT;
                end
            end

            SHIFT: begin
                // fill_r is consumed from bit 0, so bit 0 is always fill[i]
                if (dir_r == DIR_LEFT) begin
                    select     = SEL_SHL;
                    s_left_din = fill_r[0];
                end else begin
                    select      = SEL_SHR;
                    s_right_din = fill_r[0];
                end
                if (count_r == CW'(1)) begin
                    next_state = CAPTURE;
                end
            end

            CAPTURE: begin
                next_state = RESP;
            end

            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command capture, shift bookkeeping and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r   <= '0;
            dir_r    <= DIR_RIGHT;
            fill_r   <= '0;
            count_r  <= '0;
            bit_mask <= '0;
            rsp_data <= '0;
            rsp_bits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        data_r   <= cmd_data;
                        dir_r    <= cmd_dir;
                        fill_r   <= cmd_fill;
                        count_r  <= count_clamped;
                        bit_mask <= WIDTH'(1);
                        rsp_data <= '0;
                        rsp_bits <= '0;
                    end
                end

                SHIFT: begin
                    // The register updates at this same edge, so exit_bit is
                    // still the bit about to leave on this shift.
                    count_r  <= count_r - CW'(1);
                    fill_r   <= fill_r >> 1;
                    bit_mask <= bit_mask << 1;
                    if (exit_bit) begin
                        rsp_bits <= rsp_bits | bit_mask;
                    end
                end

                CAPTURE: begin
                    rsp_data <= p_dout;
                end

                default: begin
                end
            endcase
        end
    end

endmodule : shift_cmd_sequencer

// File: tb/tb_shift_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_cmd_sequencer
//
// Directed bench for shift_cmd_sequencer with WIDTH=4. A small behavioural
// universal shift register sits beside the sequencer, as it would at the
// parent level. Expected responses are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_shift_cmd_sequencer;
    import shift_cmd_sequencer_pkg::*;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [CW-1:0]    cmd_count;
    logic [WIDTH-1:0] cmd_fill;
    logic [1:0]       select;
    logic [WIDTH-1:0] p_din;
    logic             s_left_din;
    logic             s_right_din;
    logic [WIDTH-1:0] p_dout;
    logic             s_left_dout;
    logic             s_right_dout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] rsp_bits;

    int assertions = 0;
    int failures   = 0;

    shift_cmd_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_dir      (cmd_dir),
        .cmd_count    (cmd_count),
        .cmd_fill     (cmd_fill),
        .select       (select),
        .p_din        (p_din),
        .s_left_din   (s_left_din),
        .s_right_din  (s_right_din),
        .p_dout       (p_dout),
        .s_left_dout  (s_left_dout),
        .s_right_dout (s_right_dout),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_bits     (rsp_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal shift register: a right shift enters at the MSB and exits
    // at bit 0 (s_left_dout), a left shift enters at bit 0 and exits at
    // the MSB (s_right_dout).
    logic [WIDTH-1:0] usr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            usr_q <= '0;
        end else begin
            case (select)
                SEL_SHR:  usr_q <= {s_right_din, usr_q[WIDTH-1:1]};
                SEL_SHL:  usr_q <= {usr_q[WIDTH-2:0], s_left_din};
                SEL_LOAD: usr_q <= p_din;
                default:  usr_q <= usr_q;
            endcase
        end
    end

    assign p_dout       = usr_q;
    assign s_left_dout  = usr_q[0];
    assign s_right_dout = usr_q[WIDTH-1];

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    // Offer a command once cmd_ready is seen, hold it through one rising
    // edge and return 1ns after that acceptance edge.
    task automatic applyStimulus(input logic [3:0] data, input logic dir,
                                 input logic [2:0] count, input logic [3:0] fill);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_data  = data;
        cmd_dir   = dir;
        cmd_count = count;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Walk the LOAD, SHIFT x n, CAPTURE cycles and stop in the first RESP
    // cycle, checking the drive pattern and the response.
    task automatic expectSequence(input logic [3:0] data, input logic dir,
                                  input int n_shifts, input logic [3:0] fill,
                                  input logic [3:0] exp_data, input logic [3:0] exp_bits);
        @(negedge clk);
        checkOutput("load_select", 32'(select), 3);
        checkOutput("load_p_din", 32'(p_din), 32'(data));
        checkOutput("load_rsp_valid", 32'(rsp_valid), 0);
        for (int k = 0; k < n_shifts; k++) begin
            @(negedge clk);
            checkOutput("shift_select", 32'(select), dir ? 2 : 1);
            if (dir) begin
                checkOutput("shift_s_left_din", 32'(s_left_din), 32'(fill >> k) & 1);
                checkOutput("shift_s_right_din", 32'(s_right_din), 0);
            end else begin
                checkOutput("shift_s_right_din", 32'(s_right_din), 32'(fill >> k) & 1);
                checkOutput("shift_s_left_din", 32'(s_left_din), 0);
            end
            checkOutput("shift_rsp_valid", 32'(rsp_valid), 0);
        end
        @(negedge clk);
        checkOutput("capture_select", 32'(select), 0);
        checkOutput("capture_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        checkOutput("resp_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("resp_rsp_data", 32'(rsp_data), 32'(exp_data));
        checkOutput("resp_rsp_bits", 32'(rsp_bits), 32'(exp_bits));
        checkOutput("resp_select", 32'(select), 0);
        checkOutput("resp_p_din", 32'(p_din), 0);
        checkOutput("resp_cmd_ready", 32'(cmd_ready), 0);
    endtask

    // Complete the response handshake from inside RESP
    task automatic finishResponse();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("post_cmd_ready", 32'(cmd_ready), 1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_dir   = 1'b0;
        cmd_count = '0;
        cmd_fill  = '0;
        rsp_ready = 1'b0;

        // Reset state
        #12;
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 0);
        checkOutput("reset_select", 32'(select), 0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 0);
        checkOutput("reset_rsp_bits", 32'(rsp_bits), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("release_cmd_ready", 32'(cmd_ready), 1);

        $display("[TB] load-only command");
        applyStimulus(4'hA, 1'b0, 3'd0, 4'h0);
        expectSequence(4'hA, 1'b0, 0, 4'h0, 4'hA, 4'h0);
        finishResponse();

        $display("[TB] right shift by 2");
        applyStimulus(4'b1011, 1'b0, 3'd2, 4'b0001);
        expectSequence(4'b1011, 1'b0, 2, 4'b0001, 4'b0110, 4'b0011);
        finishResponse();

        $display("[TB] left shift by 4");
        applyStimulus(4'b1001, 1'b1, 3'd4, 4'b0000);
        expectSequence(4'b1001, 1'b1, 4, 4'b0000, 4'b0000, 4'b1001);
        finishResponse();

        $display("[TB] count clamp 7 -> 4");
        applyStimulus(4'hF, 1'b0, 3'd7, 4'h0);
        expectSequence(4'hF, 1'b0, 4, 4'h0, 4'h0, 4'hF);
        finishResponse();

        $display("[TB] left shift by 2 with fill");
        applyStimulus(4'b0110, 1'b1, 3'd2, 4'b0010);
        expectSequence(4'b0110, 1'b1, 2, 4'b0010, 4'b1001, 4'b0010);
        finishResponse();

        $display("[TB] response backpressure");
        applyStimulus(4'b0101, 1'b0, 3'd1, 4'b0001);
        expectSequence(4'b0101, 1'b0, 1, 4'b0001, 4'b1010, 4'b0001);
        cmd_data  = 4'h3;
        cmd_dir   = 1'b0;
        cmd_count = 3'd0;
        cmd_fill  = 4'h0;
        cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
            checkOutput("bp_rsp_data", 32'(rsp_data), 'hA);
            checkOutput("bp_rsp_bits", 32'(rsp_bits), 'h1);
            checkOutput("bp_cmd_ready", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        // Handshake edge returns to IDLE; the held command is not taken yet
        checkOutput("bp_idle_select", 32'(select), 0);
        checkOutput("bp_idle_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("bp_idle_cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        expectSequence(4'h3, 1'b0, 0, 4'h0, 4'h3, 4'h0);
        finishResponse();

        $display("[TB] reset during second shift");
        applyStimulus(4'b1101, 1'b0, 3'd4, 4'h0);
        @(negedge clk);
        checkOutput("rst_load_select", 32'(select), 3);
        @(negedge clk);
        checkOutput("rst_shift1_select", 32'(select), 1);
        @(negedge clk);
        checkOutput("rst_shift2_select", 32'(select), 1);
        checkOutput("rst_shift2_rsp_bits", 32'(rsp_bits), 'h1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_select", 32'(select), 0);
        checkOutput("rst_mid_p_din", 32'(p_din), 0);
        checkOutput("rst_mid_s_right_din", 32'(s_right_din), 0);
        checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_mid_rsp_bits", 32'(rsp_bits), 0);
        checkOutput("rst_mid_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_cmd_ready", 32'(cmd_ready), 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("rst_no_rsp_valid", 32'(rsp_valid), 0);
            checkOutput("rst_idle_select", 32'(select), 0);
        end

        $display("[TB] recovery after reset");
        applyStimulus(4'b1100, 1'b1, 3'd1, 4'b0001);
        expectSequence(4'b1100, 1'b1, 1, 4'b0001, 4'b1001, 4'b0001);
        finishResponse();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule : tb_shift_cmd_sequencer
